// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared frame constants, register map and receiver state type
package dds_pkg;

  localparam int FRAME_BITS = 24;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 16;

  localparam logic [ADDR_BITS-1:0] ADDR_FREQ0  = 8'h00;
  localparam logic [ADDR_BITS-1:0] ADDR_FREQ1  = 8'h01;
  localparam logic [ADDR_BITS-1:0] ADDR_PHASE0 = 8'h02;
  localparam logic [ADDR_BITS-1:0] ADDR_PHASE1 = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } spi_state_t;

endpackage

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI mode 0 frame receiver: edge detect, bit count, shifter, FSM
// Readback side-band ports exist only with DDS_SPI_READBACK_EN.
module spi_frame_rx
  import dds_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_clock,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] data,
  output logic                 commit,
  output logic                 err
`ifdef DDS_SPI_READBACK_EN
  ,
  output logic                 rd_load,
  output logic                 sck_fall,
  output logic                 in_data
`endif
);

  logic                 sck_d;
  logic                 cs_d;
  logic                 sck_rise;
  logic                 cs_rise;
  logic                 cs_fall;
  spi_state_t           state;
  logic [4:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  assign sck_rise = spi_clock & ~sck_d;
  assign cs_rise  = spi_cs_n & ~cs_d;
  assign cs_fall  = ~spi_cs_n & cs_d;

  // Strobes are taken straight from the edge so the top can write one cycle after cs rises.
  assign commit = (state == ST_DONE) && cs_rise;
  assign err    = cs_rise && ((state == ST_ADDR) || (state == ST_DATA) || (state == ST_ERR));
  assign data   = shreg;

`ifdef DDS_SPI_READBACK_EN
  assign sck_fall = ~spi_clock & sck_d;
  assign in_data  = (state == ST_DATA);
`endif

  // cs_d resets low so a cs held low through reset never looks like a fresh fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_d   <= 1'b0;
      cs_d    <= 1'b0;
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      addr    <= '0;
`ifdef DDS_SPI_READBACK_EN
      rd_load <= 1'b0;
`endif
    end else begin
      sck_d <= spi_clock;
      cs_d  <= spi_cs_n;
`ifdef DDS_SPI_READBACK_EN
      rd_load <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            bit_cnt <= '0;
            shreg   <= '0;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (cs_rise) begin
            state <= ST_IDLE;
          end else if (sck_rise) begin
            shreg   <= {shreg[DATA_BITS-2:0], spi_mosi};
            bit_cnt <= bit_cnt + 5'd1;
            if ((state == ST_ADDR) && (bit_cnt == 5'(ADDR_BITS - 1))) begin
              addr  <= {shreg[ADDR_BITS-2:0], spi_mosi};
              state <= ST_DATA;
`ifdef DDS_SPI_READBACK_EN
              rd_load <= 1'b1;
`endif
            end else if ((state == ST_DATA) && (bit_cnt == 5'(FRAME_BITS - 1))) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (cs_rise) begin
            state <= ST_IDLE;
          end else if (sck_rise) begin
            state <= ST_ERR;
          end
        end
        ST_ERR: begin
          if (cs_rise) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dds_spi_regs.sv
// rtl/dds_spi_regs.sv - DDS tuning registers written over SPI, with select muxes
// Optional readback on spi_miso is enabled by DDS_SPI_READBACK_EN.
module dds_spi_regs
  import dds_pkg::*;
#(
  parameter int FREQ_W  = 16,
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spi_clock,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  input  logic               fselect,
  input  logic               pselect,
  output logic [FREQ_W-1:0]  freq_word,
  output logic [PHASE_W-1:0] phase_word,
  output logic               reg_wr,
  output logic               frame_err
`ifdef DDS_SPI_READBACK_EN
  ,
  output logic               spi_miso
`endif
);

  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] data;
  logic                 commit;
  logic                 err;
  logic [FREQ_W-1:0]    freq0, freq1;
  logic [PHASE_W-1:0]   phase0, phase1;
  logic                 unused_data_bits;

  assign unused_data_bits = ^data;

`ifdef DDS_SPI_READBACK_EN
  logic                 rd_load;
  logic                 sck_fall;
  logic                 in_data;
  logic [DATA_BITS-1:0] rd_word;
  logic [DATA_BITS-1:0] rd_sh;
`endif

  spi_frame_rx u_rx (
    .clk       (clk),
    .reset     (reset),
    .spi_clock (spi_clock),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .addr      (addr),
    .data      (data),
    .commit    (commit),
    .err       (err)
`ifdef DDS_SPI_READBACK_EN
    ,
    .rd_load   (rd_load),
    .sck_fall  (sck_fall),
    .in_data   (in_data)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq0      <= '0;
      freq1      <= '0;
      phase0     <= '0;
      phase1     <= '0;
      freq_word  <= '0;
      phase_word <= '0;
      reg_wr     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      frame_err <= err;
      if (commit) begin
        case (addr)
          ADDR_FREQ0:  begin freq0  <= data[FREQ_W-1:0];  reg_wr <= 1'b1; end
          ADDR_FREQ1:  begin freq1  <= data[FREQ_W-1:0];  reg_wr <= 1'b1; end
          ADDR_PHASE0: begin phase0 <= data[PHASE_W-1:0]; reg_wr <= 1'b1; end
          ADDR_PHASE1: begin phase1 <= data[PHASE_W-1:0]; reg_wr <= 1'b1; end
          default:     frame_err <= 1'b1;
        endcase
      end
      // Whole-word re-registration keeps the accumulator from seeing a torn update.
      freq_word  <= fselect ? freq1 : freq0;
      phase_word <= pselect ? phase1 : phase0;
    end
  end

`ifdef DDS_SPI_READBACK_EN
  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_FREQ0:  rd_word = 16'(freq0);
      ADDR_FREQ1:  rd_word = 16'(freq1);
      ADDR_PHASE0: rd_word = 16'(phase0);
      ADDR_PHASE1: rd_word = 16'(phase1);
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sh    <= '0;
      spi_miso <= 1'b0;
    end else if (rd_load) begin
      rd_sh <= rd_word;
    end else if (!in_data) begin
      spi_miso <= 1'b0;
    end else if (sck_fall) begin
      spi_miso <= rd_sh[DATA_BITS-1];
      rd_sh    <= {rd_sh[DATA_BITS-2:0], 1'b0};
    end
  end
`endif

endmodule

// File: tb/tb_dds_spi_regs.sv
// tb/tb_dds_spi_regs.sv - directed table-driven bench for dds_spi_regs
module tb_dds_spi_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_clock = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        fselect = 1'b0;
  logic        pselect = 1'b0;
  logic [15:0] freq_word;
  logic [7:0]  phase_word;
  logic        reg_wr;
  logic        frame_err;
  logic        miso_w;
  logic [31:0] miso_cap = '0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic        fsel;
    logic        psel;
    logic        wr;
    logic        err;
    logic [15:0] freq;
    logic [7:0]  phase;
  } vec_t;

  vec_t vecs[7];

  dds_spi_regs #(.FREQ_W(16), .PHASE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clock  (spi_clock),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .fselect    (fselect),
    .pselect    (pselect),
    .freq_word  (freq_word),
    .phase_word (phase_word),
    .reg_wr     (reg_wr),
    .frame_err  (frame_err)
`ifdef DDS_SPI_READBACK_EN
    ,
    .spi_miso   (miso_w)
`endif
  );

`ifndef DDS_SPI_READBACK_EN
  assign miso_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      tick(4);
      miso_cap = {miso_cap[30:0], miso_w};
      spi_clock = 1'b1;
      tick(4);
      spi_clock = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int n);
    spi_cs_n = 1'b0;
    tick(4);
    spi_bits(bits, n);
    tick(4);
    spi_cs_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'h00_1234, 24, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'h00};
    vecs[1] = '{32'h01_BEEF, 24, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'h00};
    vecs[2] = '{32'h02_5A77, 24, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'h77};
    vecs[3] = '{32'h01_0008, 23, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'h77};
    vecs[4] = '{32'h06_0199, 25, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 8'h00};
    vecs[5] = '{32'h07_FFFF, 24, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'h77};
    vecs[6] = '{32'h03_0042, 24, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h42};

    tick(2);
    chk("rst_freq", 32'(freq_word), 32'h0);
    chk("rst_phase", 32'(phase_word), 32'h0);
    chk("rst_reg_wr", 32'(reg_wr), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    tick(2);

    for (int v = 0; v < 7; v++) begin
      fselect = vecs[v].fsel;
      pselect = vecs[v].psel;
      spi_frame(vecs[v].bits, vecs[v].nbits);
      tick(1);
      chk($sformatf("v%0d_reg_wr", v), 32'(reg_wr), 32'(vecs[v].wr));
      chk($sformatf("v%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].err));
      tick(1);
      chk($sformatf("v%0d_pulse_end", v), 32'({reg_wr, frame_err}), 32'h0);
      chk($sformatf("v%0d_freq", v), 32'(freq_word), 32'(vecs[v].freq));
      chk($sformatf("v%0d_phase", v), 32'(phase_word), 32'(vecs[v].phase));
      tick(4);
    end

    pselect = 1'b0;
    fselect = 1'b0;
    tick(1);
    chk("fsel0_freq", 32'(freq_word), 32'h1234);
    fselect = 1'b1;
    tick(1);
    chk("fsel1_freq", 32'(freq_word), 32'hBEEF);

`ifdef DDS_SPI_READBACK_EN
    miso_cap = '0;
    spi_frame(32'h01_BEEF, 24);
    chk("readback_bits", 32'(miso_cap[15:0]), 32'hBEEF);
    tick(2);
    chk("readback_idle", 32'(miso_w), 32'h0);
    tick(4);
`endif

    pselect = 1'b1;
    spi_cs_n = 1'b0;
    tick(4);
    spi_bits(32'h00_0FFF, 12);
    #2 reset = 1'b1;
    #1;
    chk("midrst_freq", 32'(freq_word), 32'h0);
    chk("midrst_phase", 32'(phase_word), 32'h0);
    chk("midrst_pulses", 32'({reg_wr, frame_err, miso_w}), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(2);

    spi_bits(32'h03_00BB, 24);
    tick(4);
    spi_cs_n = 1'b1;
    tick(1);
    chk("nofall_pulses", 32'({reg_wr, frame_err}), 32'h0);
    tick(1);
    chk("nofall_phase", 32'(phase_word), 32'h0);
    tick(4);

    spi_frame(32'h03_00AA, 24);
    tick(1);
    chk("post_rst_reg_wr", 32'(reg_wr), 32'h1);
    tick(1);
    chk("post_rst_phase", 32'(phase_word), 32'hAA);
    chk("post_rst_freq", 32'(freq_word), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
